// File: rtl/complex_nr_accumulator.sv
// Sums NR_TERMS consecutive complex products from the multiplier into one complex
// dot-product result and presents it on a registered valid/ready output.
module complex_nr_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int NR_TERMS   = 4,
    parameter int ACC_GUARD  = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  sw_rst,
    input  logic                                  res_val,
    output logic                                  res_ready,
    input  logic [2*DATA_WIDTH-1:0]               result_re,
    input  logic [2*DATA_WIDTH-1:0]               result_im,
    output logic                                  acc_val,
    input  logic                                  acc_ready,
    output logic [2*DATA_WIDTH+ACC_GUARD-1:0]     acc_re,
    output logic [2*DATA_WIDTH+ACC_GUARD-1:0]     acc_im,
    output logic [7:0]                            acc_cnt
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + ACC_GUARD;
    localparam int CNT_W = (NR_TERMS > 2) ? $clog2(NR_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NR_TERMS - 1);

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   term_q, term_d;
    logic [ACC_W-1:0]   sum_re_q, sum_re_d;
    logic [ACC_W-1:0]   sum_im_q, sum_im_d;
    logic [ACC_W-1:0]   acc_re_q, acc_re_d;
    logic [ACC_W-1:0]   acc_im_q, acc_im_d;
    logic               res_ready_q, res_ready_d;
    logic               acc_val_q, acc_val_d;
    logic [7:0]         acc_cnt_q, acc_cnt_d;

    logic               in_xfer;
    logic               out_xfer;
    logic [ACC_W-1:0]   add_re;
    logic [ACC_W-1:0]   add_im;

    assign in_xfer  = res_val & res_ready_q;
    assign out_xfer = acc_ready & acc_val_q;

    // Two's complement add after sign extension into the guard bits
    assign add_re = sum_re_q + {{ACC_GUARD{result_re[PW-1]}}, result_re};
    assign add_im = sum_im_q + {{ACC_GUARD{result_im[PW-1]}}, result_im};

    always_comb begin
        state_d     = state_q;
        term_d      = term_q;
        sum_re_d    = sum_re_q;
        sum_im_d    = sum_im_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        res_ready_d = res_ready_q;
        acc_val_d   = acc_val_q;
        acc_cnt_d   = acc_cnt_q;

        case (state_q)
            ACCUM: begin
                res_ready_d = 1'b1;
                acc_val_d   = 1'b0;
                if (in_xfer) begin
                    if (term_q == LAST_TERM) begin
                        acc_re_d    = add_re;
                        acc_im_d    = add_im;
                        sum_re_d    = '0;
                        sum_im_d    = '0;
                        term_d      = '0;
                        state_d     = DONE;
                        acc_val_d   = 1'b1;
                        res_ready_d = 1'b0;
                    end else begin
                        sum_re_d = add_re;
                        sum_im_d = add_im;
                        term_d   = term_q + 1'b1;
                    end
                end
            end
            DONE: begin
                res_ready_d = 1'b0;
                if (out_xfer) begin
                    acc_cnt_d   = acc_cnt_q + 8'd1;
                    acc_val_d   = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        // Software clear wins over any transfer in the same cycle
        if (sw_rst) begin
            state_d     = ACCUM;
            term_d      = '0;
            sum_re_d    = '0;
            sum_im_d    = '0;
            acc_re_d    = '0;
            acc_im_d    = '0;
            acc_val_d   = 1'b0;
            acc_cnt_d   = '0;
            res_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ACCUM;
            term_q      <= '0;
            sum_re_q    <= '0;
            sum_im_q    <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            res_ready_q <= 1'b0;
            acc_val_q   <= 1'b0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            term_q      <= term_d;
            sum_re_q    <= sum_re_d;
            sum_im_q    <= sum_im_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            res_ready_q <= res_ready_d;
            acc_val_q   <= acc_val_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign res_ready = res_ready_q;
    assign acc_val   = acc_val_q;
    assign acc_re    = acc_re_q;
    assign acc_im    = acc_im_q;
    assign acc_cnt   = acc_cnt_q;

endmodule
